// File: rtl/track_cmd_gen.sv
// Track-step pulse generator: merges two debounced, auto-repeating buttons and a
// UART command stream into spaced one-cycle PREV/NEXT step pulses.
module track_cmd_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned HOLD_CYCLES     = 50000000,
    parameter int unsigned REPEAT_CYCLES   = 20000000,
    parameter int unsigned GAP_CYCLES      = 500001
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN_PREV,
    input  logic       BTN_NEXT,
    input  logic [7:0] CMD_DATA,
    input  logic       CMD_VALID,
    output logic       CMD_READY,
    output logic [2:0] PREV,
    output logic [2:0] NEXT
);

    localparam int unsigned HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam int unsigned GAP_W    = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EMIT,
        S_GAP
    } state_e;

    state_e state_q, state_d;

    // Per-button vectors: bit 0 = PREV button, bit 1 = NEXT button.
    logic [1:0]        btn_raw;
    logic [1:0]        sync1_q, sync2_q;
    logic [1:0]        stable_q, stable_d;
    logic [1:0]        rep_q, rep_d;
    logic [1:0]        btn_evt;
    logic [DB_W-1:0]   db_cnt_q   [2];
    logic [DB_W-1:0]   db_cnt_d   [2];
    logic [HOLD_W-1:0] hold_cnt_q [2];
    logic [HOLD_W-1:0] hold_cnt_d [2];

    logic              slot_full_q, slot_full_d;
    logic              slot_prev_q, slot_prev_d;
    logic [2:0]        slot_step_q, slot_step_d;

    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [2:0]        prev_q, prev_d;
    logic [2:0]        next_q, next_d;

    logic              cmd_accept;
    logic              cmd_hit;
    logic              cmd_prev;
    logic [2:0]        cmd_step;

    assign btn_raw = {BTN_NEXT, BTN_PREV};

    always_comb begin
        stable_d = stable_q;
        rep_d    = rep_q;
        btn_evt  = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            db_cnt_d[i]   = '0;
            hold_cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] >= DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
            if (stable_d[i] && !stable_q[i]) begin
                btn_evt[i] = 1'b1;
            end
            // Hold counter doubles as the repeat-period counter once rep_q is set.
            if (!stable_q[i]) begin
                rep_d[i] = 1'b0;
            end else begin
                hold_cnt_d[i] = (hold_cnt_q[i] == '1) ? hold_cnt_q[i] : hold_cnt_q[i] + 1'b1;
                if (hold_cnt_d[i] == HOLD_W'(rep_q[i] ? REPEAT_CYCLES : HOLD_CYCLES)) begin
                    btn_evt[i]    = 1'b1;
                    hold_cnt_d[i] = '0;
                    rep_d[i]      = 1'b1;
                end
            end
        end
    end

    always_comb begin
        cmd_hit  = 1'b0;
        cmd_prev = 1'b0;
        cmd_step = 3'd0;
        case (CMD_DATA)
            8'h70: begin cmd_hit = 1'b1; cmd_prev = 1'b1; cmd_step = 3'd1; end
            8'h6E: begin cmd_hit = 1'b1; cmd_prev = 1'b0; cmd_step = 3'd1; end
            8'h3C: begin cmd_hit = 1'b1; cmd_prev = 1'b1; cmd_step = 3'd4; end
            8'h3E: begin cmd_hit = 1'b1; cmd_prev = 1'b0; cmd_step = 3'd4; end
            default: ;
        endcase
        CMD_READY  = !slot_full_q && (btn_evt == 2'b00);
        cmd_accept = CMD_VALID && CMD_READY;
    end

    always_comb begin
        slot_full_d = slot_full_q;
        slot_prev_d = slot_prev_q;
        slot_step_d = slot_step_q;
        if (state_q == S_EMIT) begin
            slot_full_d = 1'b0;
        end else if (!slot_full_q) begin
            if (btn_evt[0]) begin
                slot_full_d = 1'b1;
                slot_prev_d = 1'b1;
                slot_step_d = 3'd1;
            end else if (btn_evt[1]) begin
                slot_full_d = 1'b1;
                slot_prev_d = 1'b0;
                slot_step_d = 3'd1;
            end else if (cmd_accept && cmd_hit) begin
                slot_full_d = 1'b1;
                slot_prev_d = cmd_prev;
                slot_step_d = cmd_step;
            end
        end
    end

    // FSM next-state
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = '0;
        case (state_q)
            S_IDLE: begin
                if (slot_full_q) begin
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                state_d = S_GAP;
            end
            S_GAP: begin
                if (gap_cnt_q >= GAP_W'(GAP_CYCLES - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        prev_d = 3'd0;
        next_d = 3'd0;
        if (state_q == S_EMIT) begin
            if (slot_prev_q) begin
                prev_d = slot_step_q;
            end else begin
                next_d = slot_step_q;
            end
        end
    end

    // FSM state register and all other flops
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            sync1_q     <= '0;
            sync2_q     <= '0;
            stable_q    <= '0;
            rep_q       <= '0;
            db_cnt_q    <= '{default: '0};
            hold_cnt_q  <= '{default: '0};
            slot_full_q <= 1'b0;
            slot_prev_q <= 1'b0;
            slot_step_q <= 3'd0;
            gap_cnt_q   <= '0;
            prev_q      <= 3'd0;
            next_q      <= 3'd0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= btn_raw;
            sync2_q     <= sync1_q;
            stable_q    <= stable_d;
            rep_q       <= rep_d;
            db_cnt_q    <= db_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            slot_full_q <= slot_full_d;
            slot_prev_q <= slot_prev_d;
            slot_step_q <= slot_step_d;
            gap_cnt_q   <= gap_cnt_d;
            prev_q      <= prev_d;
            next_q      <= next_d;
        end
    end

    assign PREV = prev_q;
    assign NEXT = next_q;

endmodule

// File: tb/tb_track_cmd_gen.sv
// Directed self-checking bench for track_cmd_gen with shortened timing parameters
// (debounce 4, hold 20, repeat 10, gap 8).
module tb_track_cmd_gen;

    logic       CLK = 1'b0;
    logic       RST;
    logic       BTN_PREV;
    logic       BTN_NEXT;
    logic [7:0] CMD_DATA;
    logic       CMD_VALID;
    logic       CMD_READY;
    logic [2:0] PREV;
    logic [2:0] NEXT;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    track_cmd_gen #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (20),
        .REPEAT_CYCLES  (10),
        .GAP_CYCLES     (8)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .BTN_PREV (BTN_PREV),
        .BTN_NEXT (BTN_NEXT),
        .CMD_DATA (CMD_DATA),
        .CMD_VALID(CMD_VALID),
        .CMD_READY(CMD_READY),
        .PREV     (PREV),
        .NEXT     (NEXT)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [2:0] exp_prev, input logic [2:0] exp_next);
        checks++;
        assert ({PREV, NEXT} === {exp_prev, exp_next}) else begin
            errors++;
            $error("FAIL %s: observed PREV=%0d NEXT=%0d expected PREV=%0d NEXT=%0d",
                   tag, PREV, NEXT, exp_prev, exp_next);
        end
    endtask

    task automatic chk_rdy(input string tag, input logic exp_rdy);
        checks++;
        assert (CMD_READY === exp_rdy) else begin
            errors++;
            $error("FAIL %s: observed CMD_READY=%b expected %b", tag, CMD_READY, exp_rdy);
        end
    endtask

    task automatic idle_run(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk_out(tag, 3'd0, 3'd0);
        end
    endtask

    task automatic pulse(input string tag, input logic [2:0] exp_prev, input logic [2:0] exp_next);
        tick();
        chk_out(tag, exp_prev, exp_next);
    endtask

    initial begin
        RST       = 1'b1;
        BTN_PREV  = 1'b0;
        BTN_NEXT  = 1'b1;
        CMD_DATA  = 8'h00;
        CMD_VALID = 1'b0;

        // Reset held with NEXT pressed
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("rst_out", 3'd0, 3'd0);
            chk_rdy("rst_rdy", 1'b1);
        end
        RST = 1'b0;
        idle_run("rst_wait", 7);
        pulse("rst_next", 3'd0, 3'd1);
        BTN_NEXT = 1'b0;
        idle_run("rst_quiet", 20);

        // Bounce shorter than debounce window
        for (int i = 0; i < 20; i++) begin
            BTN_PREV = ((i % 4) < 2);
            tick();
            chk_out("bounce", 3'd0, 3'd0);
        end
        BTN_PREV = 1'b0;
        idle_run("bounce_settle", 10);
        BTN_PREV = 1'b1;
        idle_run("press_wait", 7);
        pulse("press_prev", 3'd1, 3'd0);
        BTN_PREV = 1'b0;
        idle_run("press_once", 20);

        // Long press with auto-repeat
        BTN_NEXT = 1'b1;
        idle_run("long_wait", 7);
        pulse("long_press", 3'd0, 3'd1);
        idle_run("long_hold", 19);
        pulse("long_rep20", 3'd0, 3'd1);
        idle_run("long_r30w", 9);
        pulse("long_rep30", 3'd0, 3'd1);
        idle_run("long_r40w", 9);
        pulse("long_rep40", 3'd0, 3'd1);
        idle_run("long_r50w", 9);
        pulse("long_rep50", 3'd0, 3'd1);
        BTN_NEXT = 1'b0;
        idle_run("long_release", 25);

        // UART bytes under backpressure
        CMD_VALID = 1'b1;
        CMD_DATA  = 8'h3E;
        chk_rdy("uart_rdy_first", 1'b1);
        tick();
        chk_out("uart_acc1", 3'd0, 3'd0);
        chk_rdy("uart_full1", 1'b0);
        CMD_DATA = 8'h70;
        tick();
        chk_out("uart_emit1", 3'd0, 3'd0);
        chk_rdy("uart_full2", 1'b0);
        pulse("uart_next4", 3'd0, 3'd4);
        chk_rdy("uart_free1", 1'b1);
        tick();
        CMD_DATA = 8'h41;
        chk_out("uart_acc2", 3'd0, 3'd0);
        chk_rdy("uart_full3", 1'b0);
        idle_run("uart_gap", 8);
        chk_rdy("uart_full4", 1'b0);
        pulse("uart_prev1", 3'd1, 3'd0);
        chk_rdy("uart_free2", 1'b1);
        tick();
        CMD_VALID = 1'b0;
        chk_out("uart_acc3", 3'd0, 3'd0);
        chk_rdy("uart_discard", 1'b1);
        idle_run("uart_quiet", 20);

        // Both buttons plus a pending 'n' byte
        BTN_PREV = 1'b1;
        BTN_NEXT = 1'b1;
        idle_run("col_wait", 5);
        CMD_VALID = 1'b1;
        CMD_DATA  = 8'h6E;
        chk_rdy("col_rdy_evt", 1'b0);
        tick();
        chk_out("col_load", 3'd0, 3'd0);
        chk_rdy("col_rdy_full", 1'b0);
        idle_run("col_emit", 1);
        pulse("col_prev1", 3'd1, 3'd0);
        BTN_PREV = 1'b0;
        BTN_NEXT = 1'b0;
        chk_rdy("col_rdy_free", 1'b1);
        tick();
        CMD_VALID = 1'b0;
        chk_out("col_acc", 3'd0, 3'd0);
        chk_rdy("col_rdy_byte", 1'b0);
        idle_run("col_gap", 8);
        pulse("col_next1", 3'd0, 3'd1);
        idle_run("col_quiet", 25);

        // Reset during GAP with '<' pending
        CMD_VALID = 1'b1;
        CMD_DATA  = 8'h6E;
        tick();
        CMD_DATA = 8'h3C;
        tick();
        pulse("rg_next1", 3'd0, 3'd1);
        chk_rdy("rg_rdy_free", 1'b1);
        tick();
        CMD_VALID = 1'b0;
        chk_rdy("rg_slot_full", 1'b0);
        tick();
        RST = 1'b1;
        tick();
        chk_out("rg_rst_out", 3'd0, 3'd0);
        chk_rdy("rg_rst_rdy", 1'b1);
        RST = 1'b0;
        idle_run("rg_no_prev4", 30);
        CMD_VALID = 1'b1;
        CMD_DATA  = 8'h6E;
        chk_rdy("rg_rdy_after", 1'b1);
        tick();
        CMD_VALID = 1'b0;
        chk_out("rg_acc", 3'd0, 3'd0);
        idle_run("rg_emit", 1);
        pulse("rg_idle_next1", 3'd0, 3'd1);
        idle_run("rg_quiet", 12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
